hazard_forward_ctrl: RTL and testbench

- Pipeline controller that drives the ForwardA/ForwardB selects of the EX-stage forwarding muxes, plus the load-use stall and branch-flush controls.
- Keeps its own shadow pipeline of register-use metadata (rs1/rs2/rd/RegWrite/MemRead) for EX, MEM and WB, advanced in lockstep with the datapath pipeline registers.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers; consumes ID-stage decode fields and produces stage-control and mux-select signals.

---
 rtl/hazard_forward_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding select, load-use stall and branch-flush controller with a shadow EX/MEM/WB
// metadata pipeline. Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_valid,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              EX_BranchTaken,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              PC_Stall,
  output logic              IFID_Stall,
  output logic              IDEX_Bubble,
  output logic              IFID_Flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  // state | meaning
  // RUN   | normal issue; a load-use hazard in ID stalls the front end for one cycle
  // STALL | bubble sits in EX, load has moved to MEM; front end released next cycle
  localparam logic S_RUN   = 1'b0;
  localparam logic S_STALL = 1'b1;

  logic r_state;
  logic w_state_nxt;

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;

  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;

  logic w_mem_wr;
  logic w_wb_wr;
  logic w_hazard;

  // Shadow pipeline never stalls: EX takes ID or a bubble, older stages always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_ex_valid     <= ID_valid & ~IDEX_Bubble;
      r_ex_rs1       <= ID_rs1;
      r_ex_rs2       <= ID_rs2;
      r_ex_rd        <= ID_rd;
      r_ex_regwrite  <= ID_RegWrite;
      r_ex_memread   <= ID_MemRead;
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
    end
  end

  assign w_mem_wr = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);
  assign w_wb_wr  = r_wb_valid & r_wb_regwrite & (r_wb_rd != '0);

  // MEM is checked first so the youngest producer wins when both stages write the same register.
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (r_ex_valid) begin
      if (w_mem_wr && (r_mem_rd == r_ex_rs1))     ForwardA = 2'b10;
      else if (w_wb_wr && (r_wb_rd == r_ex_rs1))  ForwardA = 2'b01;
      if (w_mem_wr && (r_mem_rd == r_ex_rs2))     ForwardB = 2'b10;
      else if (w_wb_wr && (r_wb_rd == r_ex_rs2))  ForwardB = 2'b01;
    end
  end

  assign w_hazard = ID_valid & r_ex_valid & r_ex_memread & (r_ex_rd != '0) &
                    ((r_ex_rd == ID_rs1) | (r_ex_rd == ID_rs2));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_RUN;
    case (r_state)
      S_RUN:   w_state_nxt = (w_hazard & ~EX_BranchTaken) ? S_STALL : S_RUN;
      S_STALL: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // A taken branch discards the consumer in ID, so it overrides the load-use stall.
  always_comb begin
    PC_Stall    = 1'b0;
    IFID_Stall  = 1'b0;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if ((r_state == S_RUN) && w_hazard) begin
      PC_Stall    = 1'b1;
      IFID_Stall  = 1'b1;
      IDEX_Bubble = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (PC_Stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (IFID_Flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      if (((ForwardA != 2'b00) || (ForwardB != 2'b00)) && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed testbench for hazard_forward_ctrl: forwarding distances, load-use stall,
// flush priority, x0 handling and reset during a stall.
module tb_hazard_forward_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              reset;
  logic              ID_valid;
  logic [REG_AW-1:0] ID_rs1;
  logic [REG_AW-1:0] ID_rs2;
  logic [REG_AW-1:0] ID_rd;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              EX_BranchTaken;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic              PC_Stall;
  logic              IFID_Stall;
  logic              IDEX_Bubble;
  logic              IFID_Flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  int total = 0;
  int bad   = 0;

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] EXP_ONE = 1;
`else
  localparam logic [CNT_W-1:0] EXP_ONE = 0;
`endif

  hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in ID; outputs settle before the caller checks.
  task automatic issue(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr);
    ID_valid    = v;
    ID_rs1      = REG_AW'(rs1);
    ID_rs2      = REG_AW'(rs2);
    ID_rd       = REG_AW'(rd);
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    EX_BranchTaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nop();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    EX_BranchTaken = 1'b0;
    nop();
    tick();
    tick();
    total++;
    if ({ForwardA, ForwardB, PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {ForwardA, ForwardB, PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush});
    end
    total++;
    if ({stall_cnt, flush_cnt, fwd_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, fwd_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1, 2, 5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    issue(1'b1, 5, 7, 6, 1'b1, 1'b0);   // sub x6,x5,x7
    tick();
    nop();
    total++;
    if (ForwardA !== 2'b10) begin
      bad++;
      $display("FAIL b2b_fwdA got=%b exp=10", ForwardA);
    end
    total++;
    if (ForwardB !== 2'b00) begin
      bad++;
      $display("FAIL b2b_fwdB got=%b exp=00", ForwardB);
    end
    tick();
    total++;
    if (fwd_cnt !== EXP_ONE) begin
      bad++;
      $display("FAIL b2b_fwd_cnt got=%0d exp=%0d", fwd_cnt, EXP_ONE);
    end
    drain();
  endtask

  task automatic test_distance2();
    issue(1'b1, 1, 2, 5, 1'b1, 1'b0);   // add x5
    tick();
    nop();
    tick();
    issue(1'b1, 7, 5, 8, 1'b1, 1'b0);   // or x8,x7,x5
    tick();
    nop();
    total++;
    if (ForwardB !== 2'b01) begin
      bad++;
      $display("FAIL dist2_fwdB got=%b exp=01", ForwardB);
    end
    total++;
    if (ForwardA !== 2'b00) begin
      bad++;
      $display("FAIL dist2_fwdA got=%b exp=00", ForwardA);
    end
    drain();
  endtask

  task automatic test_mem_wb_same();
    issue(1'b1, 1, 2, 9, 1'b1, 1'b0);
    tick();
    issue(1'b1, 3, 4, 9, 1'b1, 1'b0);
    tick();
    issue(1'b1, 9, 9, 1, 1'b1, 1'b0);   // xor x1,x9,x9
    tick();
    nop();
    total++;
    if ({ForwardA, ForwardB} !== 4'b1010) begin
      bad++;
      $display("FAIL memwb_prio got=%b_%b exp=10_10", ForwardA, ForwardB);
    end
    drain();
  endtask

  task automatic test_load_use();
    issue(1'b1, 2, 0, 4, 1'b1, 1'b1);   // lw x4
    total++;
    if (PC_Stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_no_early_stall got=%b exp=0", PC_Stall);
    end
    tick();
    issue(1'b1, 4, 2, 3, 1'b1, 1'b0);   // add x3,x4,x2
    total++;
    if ({PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush} !== 4'b1110) begin
      bad++;
      $display("FAIL lu_stall got=%b exp=1110", {PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush});
    end
    tick();                              // front end held: add stays in ID
    total++;
    if ({PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush} !== 4'b0000) begin
      bad++;
      $display("FAIL lu_stall_one_cycle got=%b exp=0000", {PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush});
    end
    total++;
    if (stall_cnt !== EXP_ONE) begin
      bad++;
      $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, EXP_ONE);
    end
    tick();
    nop();
    total++;
    if ({ForwardA, ForwardB} !== 4'b0100) begin
      bad++;
      $display("FAIL lu_fwd got=%b_%b exp=01_00", ForwardA, ForwardB);
    end
    drain();
  endtask

  task automatic test_flush_vs_hazard();
    issue(1'b1, 2, 0, 4, 1'b1, 1'b1);   // lw x4
    tick();
    EX_BranchTaken = 1'b1;
    issue(1'b1, 4, 2, 3, 1'b1, 1'b0);
    total++;
    if ({PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush} !== 4'b0011) begin
      bad++;
      $display("FAIL flush_prio got=%b exp=0011", {PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush});
    end
    tick();
    EX_BranchTaken = 1'b0;
    nop();
    total++;
    if (dut.r_state !== 1'b0) begin
      bad++;
      $display("FAIL flush_fsm_run got=%b exp=0", dut.r_state);
    end
    total++;
    if (flush_cnt !== EXP_ONE) begin
      bad++;
      $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, EXP_ONE);
    end
    tick();
    total++;
    if ({ForwardA, ForwardB} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_bubble_fwd got=%b_%b exp=00_00", ForwardA, ForwardB);
    end
    drain();
  endtask

  task automatic test_x0();
    issue(1'b1, 2, 0, 0, 1'b1, 1'b1);   // lw x0
    tick();
    issue(1'b1, 0, 0, 3, 1'b1, 1'b0);   // add x3,x0,x0
    total++;
    if ({PC_Stall, IDEX_Bubble} !== 2'b00) begin
      bad++;
      $display("FAIL x0_no_stall got=%b exp=00", {PC_Stall, IDEX_Bubble});
    end
    tick();
    nop();
    total++;
    if ({ForwardA, ForwardB} !== 4'b0000) begin
      bad++;
      $display("FAIL x0_no_fwd_mem got=%b_%b exp=00_00", ForwardA, ForwardB);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    issue(1'b1, 2, 0, 4, 1'b1, 1'b1);   // lw x4
    tick();
    issue(1'b1, 4, 2, 3, 1'b1, 1'b0);
    tick();                              // now in STALL
    reset = 1'b1;
    tick();
    total++;
    if ({ForwardA, ForwardB, PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush} !== 8'h00) begin
      bad++;
      $display("FAIL rst_stall_outputs got=%b exp=00000000",
               {ForwardA, ForwardB, PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush});
    end
    total++;
    if ({stall_cnt, flush_cnt, fwd_cnt} !== '0) begin
      bad++;
      $display("FAIL rst_stall_counters got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, fwd_cnt);
    end
    reset = 1'b0;
    #1;
    total++;
    if (PC_Stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_shadow_cleared got=%b exp=0", PC_Stall);
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    EX_BranchTaken = 1'b0;
    ID_valid = 1'b0; ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
    ID_RegWrite = 1'b0; ID_MemRead = 1'b0;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_mem_wb_same();
    test_load_use();
    test_flush_vs_hazard();
    test_x0();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
